// File: rtl/sevenseg_seq_ctrl.sv
// sevenseg_seq_ctrl
// Digit sequencer for the combinational BCD-to-seven-segment decoder.
// It steps a 0..MAX_DIGIT digit once every TICK_DIV clocks while running.
// It supports up/down direction, run/pause/idle control and a clamped
// parallel load from the board switches.
// Optional feature macro: SEVENSEG_TWO_DIGIT_EN adds a tens digit and a
// two-digit display scan (ports tens, digit_sel, mux_bcd).

module sevenseg_seq_ctrl #(
  parameter int unsigned TICK_DIV  = 12000000,
  parameter int unsigned MAX_DIGIT = 9,
  parameter int unsigned SCAN_DIV  = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic       up_dn,
  input  logic [3:0] ld_val,
  output logic [3:0] bcd,
  output logic       tick,
  output logic       wrap,
  output logic [1:0] state
`ifdef SEVENSEG_TWO_DIGIT_EN
  ,
  output logic [3:0] tens,
  output logic       digit_sel,
  output logic [3:0] mux_bcd
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_e;

  // The prescaler only ever holds 0..TICK_DIV-1, so clog2 bits are enough.
  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    MAX4     = 4'(MAX_DIGIT);

  // Catch unsupported parameter values at elaboration rather than in silicon.
  if (TICK_DIV < 2 || TICK_DIV > (1 << 24)) begin : g_badTickDiv
    $error("sevenseg_seq_ctrl: TICK_DIV must be in 2..2^24");
  end
  if (MAX_DIGIT < 1 || MAX_DIGIT > 15) begin : g_badMaxDigit
    $error("sevenseg_seq_ctrl: MAX_DIGIT must be in 1..15");
  end
  if (SCAN_DIV < 1) begin : g_badScanDiv
    $error("sevenseg_seq_ctrl: SCAN_DIV must be at least 1");
  end

  state_e        state_q, state_d;
  logic [3:0]    bcd_q, bcd_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic [3:0]    bcdUp, bcdDn;
  logic          bcdUpWrap, bcdDnWrap;
  logic          stepWrap;

`ifdef SEVENSEG_TWO_DIGIT_EN
  localparam int unsigned   SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [3:0]    tens_q, tens_d;
  logic [SW-1:0] scan_q, scan_d;
  logic          sel_q, sel_d;
  logic [3:0]    tensUp, tensDn;
  logic          tensUpWrap, tensDnWrap;
`endif

  // Candidate units-digit values for an up or a down step; an out-of-range digit folds back into range.
  always_comb begin
    bcdUpWrap = (bcd_q >= MAX4);
    bcdDnWrap = (bcd_q == 4'd0);
    bcdUp     = bcdUpWrap ? 4'd0 : bcd_q + 4'd1;
    if (bcdDnWrap || (bcd_q > MAX4)) begin
      bcdDn = MAX4;
    end else begin
      bcdDn = bcd_q - 4'd1;
    end
  end

`ifdef SEVENSEG_TWO_DIGIT_EN
  // Tens-digit step candidates and the free-running display scan divider.
  always_comb begin
    tensUpWrap = (tens_q >= 4'd9);
    tensDnWrap = (tens_q == 4'd0);
    tensUp     = tensUpWrap ? 4'd0 : tens_q + 4'd1;
    tensDn     = (tensDnWrap || (tens_q > 4'd9)) ? 4'd9 : tens_q - 4'd1;
    if (scan_q >= SCAN_LAST) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end else begin
      scan_d = scan_q + SW'(1);
      sel_d  = sel_q;
    end
  end
`endif

  // Command decode and stepping: load beats stop, stop beats start, and stepping only happens in RUN with no command acting.
  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    pre_d    = pre_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    stepWrap = 1'b0;
`ifdef SEVENSEG_TWO_DIGIT_EN
    tens_d   = tens_q;
`endif
    if (load) begin
      bcd_d = (ld_val > MAX4) ? MAX4 : ld_val;
      pre_d = '0;
`ifdef SEVENSEG_TWO_DIGIT_EN
      tens_d = 4'd0;
`endif
    end else if (stop) begin
      case (state_q)
        S_RUN: begin
          state_d = S_PAUSE;
        end
        S_PAUSE: begin
          state_d = S_IDLE;
          bcd_d   = 4'd0;
          pre_d   = '0;
`ifdef SEVENSEG_TWO_DIGIT_EN
          tens_d  = 4'd0;
`endif
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (start && (state_q != S_RUN)) begin
      state_d = S_RUN;
      if (state_q != S_PAUSE) begin
        pre_d = '0;
      end
    end else if (state_q == S_RUN) begin
      if (pre_q >= PRE_LAST) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (up_dn) begin
          bcd_d    = bcdUp;
          stepWrap = bcdUpWrap;
        end else begin
          bcd_d    = bcdDn;
          stepWrap = bcdDnWrap;
        end
`ifdef SEVENSEG_TWO_DIGIT_EN
        if (stepWrap) begin
          tens_d = up_dn ? tensUp : tensDn;
        end
        wrap_d = stepWrap && (up_dn ? tensUpWrap : tensDnWrap);
`else
        wrap_d = stepWrap;
`endif
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Sequencer FSM and its registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcd_q   <= 4'd0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef SEVENSEG_TWO_DIGIT_EN
      tens_q  <= 4'd0;
      scan_q  <= '0;
      sel_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
`ifdef SEVENSEG_TWO_DIGIT_EN
      tens_q  <= tens_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
`endif
    end
  end

  assign bcd   = bcd_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;
  assign state = state_q;

`ifdef SEVENSEG_TWO_DIGIT_EN
  assign tens      = tens_q;
  assign digit_sel = sel_q;
  assign mux_bcd   = sel_q ? tens_q : bcd_q;
`endif

endmodule
